// File: rtl/branch_predictor_gshare_spec_if.sv
// ============================================================================
// Module      : branch_predictor_gshare_spec_if
// Description : Request/feedback/statistics bundle between branch_controller
//               and the gshare predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_gshare_spec_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_BITS   = 8,
    parameter int STAT_BITS  = 32
);
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic                  o_req_prediction;
    logic [GHR_BITS-1:0]   o_req_ghr;
    logic                  o_ready;
    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    logic [GHR_BITS-1:0]   i_fb_ghr;
    logic                  i_fb_prediction;
    logic                  i_fb_outcome;
    logic [STAT_BITS-1:0]  o_stat_branches;
    logic [STAT_BITS-1:0]  o_stat_mispredicts;

    modport master (
        output i_req_valid, i_req_pc,
        output i_fb_valid, i_fb_pc, i_fb_ghr, i_fb_prediction, i_fb_outcome,
        input  o_req_prediction, o_req_ghr, o_ready,
        input  o_stat_branches, o_stat_mispredicts
    );

    modport slave (
        input  i_req_valid, i_req_pc,
        input  i_fb_valid, i_fb_pc, i_fb_ghr, i_fb_prediction, i_fb_outcome,
        output o_req_prediction, o_req_ghr, o_ready,
        output o_stat_branches, o_stat_mispredicts
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_gshare_spec.sv
// ============================================================================
// Module      : branch_predictor_gshare_spec
// Description : Parametrised gshare predictor with speculative history,
//               checkpoint repair, post-reset PHT sweep and saturating stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_gshare_spec #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int PC_SHIFT   = 2,
    parameter int STAT_BITS  = 32
) (
    input  wire                            clk,
    input  wire                            rst,
    branch_predictor_gshare_spec_if.slave  bus
);

    localparam int                  c_DEPTH    = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;
    localparam logic                c_TAKEN    = 1'b1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_ptr;
    logic                  r_ready;
    logic [GHR_BITS-1:0]   r_ghr;
    logic [STAT_BITS-1:0]  r_stat_branches;
    logic [STAT_BITS-1:0]  r_stat_mispredicts;
    logic [CTR_BITS-1:0]   r_pht [c_DEPTH];

    logic                  w_run;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [INDEX_BITS-1:0] w_fb_idx;
    logic [CTR_BITS-1:0]   w_req_ctr;
    logic [CTR_BITS-1:0]   w_fb_ctr;
    logic [CTR_BITS-1:0]   w_fb_ctr_next;
    logic                  w_pred;
    logic                  w_mispredict;
    logic [GHR_BITS-1:0]   w_ghr_shift;
    logic [GHR_BITS-1:0]   w_ghr_repair;
    logic                  w_pht_we;
    logic [INDEX_BITS-1:0] w_pht_waddr;
    logic [CTR_BITS-1:0]   w_pht_wdata;
    logic                  w_unused_bits;

    assign w_run     = (r_state == ST_RUN);
    assign w_req_idx = bus.i_req_pc[PC_SHIFT +: INDEX_BITS] ^ INDEX_BITS'(r_ghr);
    assign w_fb_idx  = bus.i_fb_pc[PC_SHIFT +: INDEX_BITS] ^ INDEX_BITS'(bus.i_fb_ghr);
    assign w_req_ctr = r_pht[w_req_idx];
    assign w_fb_ctr  = r_pht[w_fb_idx];

    // Reads see the table before any same-cycle training write (no bypass).
    assign w_pred       = w_run & w_req_ctr[CTR_BITS-1];
    assign w_mispredict = bus.i_fb_valid & (bus.i_fb_prediction != bus.i_fb_outcome);

    always_comb begin
        w_fb_ctr_next = w_fb_ctr;
        if (bus.i_fb_outcome == c_TAKEN) begin
            if (w_fb_ctr != c_CTR_MAX) w_fb_ctr_next = w_fb_ctr + 1'b1;
        end else begin
            if (w_fb_ctr != '0) w_fb_ctr_next = w_fb_ctr - 1'b1;
        end
    end

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign w_ghr_shift  = w_pred;
            assign w_ghr_repair = bus.i_fb_outcome;
        end else begin : g_ghr_wide
            assign w_ghr_shift  = {r_ghr[GHR_BITS-2:0], w_pred};
            assign w_ghr_repair = {bus.i_fb_ghr[GHR_BITS-2:0], bus.i_fb_outcome};
        end
    endgenerate

    // Single write port: the sweep owns it in INIT, feedback owns it in RUN.
    always_comb begin
        w_pht_we    = 1'b0;
        w_pht_waddr = r_ptr;
        w_pht_wdata = c_CTR_INIT;
        if (!rst) begin
            if (!w_run) begin
                w_pht_we = 1'b1;
            end else if (bus.i_fb_valid) begin
                w_pht_we    = 1'b1;
                w_pht_waddr = w_fb_idx;
                w_pht_wdata = w_fb_ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pht_we) r_pht[w_pht_waddr] <= w_pht_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_INIT;
            r_ptr              <= '0;
            r_ready            <= 1'b0;
            r_ghr              <= '0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Repair wins: a same-cycle request is on the squashed path.
                    if (w_mispredict) begin
                        r_ghr <= w_ghr_repair;
                    end else if (bus.i_req_valid) begin
                        r_ghr <= w_ghr_shift;
                    end
                    if (bus.i_fb_valid && (r_stat_branches != '1)) begin
                        r_stat_branches <= r_stat_branches + 1'b1;
                    end
                    if (w_mispredict && (r_stat_mispredicts != '1)) begin
                        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req_prediction   = w_pred;
    assign bus.o_req_ghr          = w_run ? r_ghr : '0;
    assign bus.o_ready            = r_ready;
    assign bus.o_stat_branches    = r_stat_branches;
    assign bus.o_stat_mispredicts = r_stat_mispredicts;

    // Only a window of each PC feeds the index; the rest is intentionally dropped.
    assign w_unused_bits = ^{bus.i_req_pc, bus.i_fb_pc, bus.i_fb_ghr};

endmodule

`default_nettype wire

// File: doc/branch_predictor_gshare_spec.md
Name: branch_predictor_gshare_spec

Overview:
Parametrised gshare conditional-branch predictor for the decode stage. It is the successor to the fixed gshare predictor and adds several features:
- bounded, parametrised PHT and GHR sizes;
- speculative global-history update at prediction time;
- history checkpoint/repair on mispredict;
- feedback-indexed PHT training;
- a sequential PHT initialisation sweep after reset;
- saturating statistics counters.

It sits behind branch_controller, which passes the request-time history checkpoint down the pipeline and returns it with the EX feedback.

Parameters:
INDEX_BITS, 10, log2 of PHT entries; PHT depth = 2**INDEX_BITS.
GHR_BITS, 8, global history length; must satisfy 1 <= GHR_BITS <= INDEX_BITS.
CTR_BITS, 2, saturating counter width; must be >= 2.
PC_SHIFT, 2, low PC bits dropped before indexing (word-aligned instructions).
STAT_BITS, 32, width of statistics counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req_valid  in  1  prediction request (conditional branch decoded, not a jump)
i_req_pc  in  ADDR_WIDTH  PC of branch in decode
o_req_prediction  out  BranchOutcome  TAKEN/NOT_TAKEN
o_req_ghr  out  GHR_BITS  history checkpoint used for this prediction; carried to EX
o_ready  out  1  1 = table initialised, predictor active
i_fb_valid  in  1  branch resolved in EX
i_fb_pc  in  ADDR_WIDTH  PC of resolved branch
i_fb_ghr  in  GHR_BITS  checkpoint returned with resolved branch
i_fb_prediction  in  BranchOutcome  prediction that was made
i_fb_outcome  in  BranchOutcome  actual outcome
o_stat_branches  out  STAT_BITS  resolved branches counted
o_stat_mispredicts  out  STAT_BITS  resolved mispredictions counted

Behaviour:
Indexing:
- idx(pc, h) = pc[PC_SHIFT +: INDEX_BITS] XOR zero-extend(h) to INDEX_BITS.
- Request index = idx(i_req_pc, ghr). Feedback index = idx(i_fb_pc, i_fb_ghr).

Counters:
- CTR_BITS wide, saturating.
- Initial value is weakly not-taken = 2**(CTR_BITS-1) - 1.
- Prediction is TAKEN iff the counter MSB is 1.
- Prediction is combinational from the current table and ghr (zero-cycle latency).

Reset:
- While rst is high: FSM = INIT, sweep pointer = 0, ghr = 0, stats = 0, o_ready = 0.

State INIT:
- Writes the initial value to PHT[ptr] each cycle and increments ptr.
- After writing entry 2**INDEX_BITS-1, transitions to RUN. o_ready goes 1 in the next cycle, i.e. exactly 2**INDEX_BITS cycles after rst deasserts.
- In INIT, o_req_prediction = NOT_TAKEN and o_req_ghr = 0. Requests and feedback are ignored: no table, ghr or stat change.

State RUN:
- Stays in RUN until rst. Reset mid-RUN restarts INIT from ptr 0 and discards all state.

GHR, speculative update:
- On i_req_valid in RUN: ghr <= {ghr[GHR_BITS-2:0], prediction}, with TAKEN = 1.
- o_req_ghr shows the pre-shift ghr.
- If GHR_BITS = 1, ghr <= prediction.

GHR, repair:
- Mispredict = i_fb_valid & (i_fb_prediction != i_fb_outcome).
- On mispredict: ghr <= {i_fb_ghr[GHR_BITS-2:0], i_fb_outcome}.
- Repair has priority over a same-cycle request shift; that request is on the wrong path and is squashed by hazard control.

Training:
- On i_fb_valid in RUN, PHT[feedback index] is incremented (TAKEN) or decremented (NOT_TAKEN), saturating at all-ones and 0.

Simultaneous request and feedback on the same entry:
- The request reads the pre-update value; there is no bypass.
- The write lands at the clock edge.

Statistics:
- o_stat_branches += 1 on each i_fb_valid in RUN.
- o_stat_mispredicts += 1 on each mispredict in RUN.
- Both saturate at all-ones and never wrap.

Storage:
- The PHT is a register array with a single write port.
- The INIT sweep is the only write source during INIT; feedback is the only write source during RUN.

Test Plan:
1. INDEX_BITS=4: assert rst 3 cycles, release -> o_ready=0 for exactly 16 cycles, then 1. Requests during INIT give NOT_TAKEN and o_req_ghr=0. Stats stay 0.
2. PC 0x40, ghr=0: feed TAKEN twice with i_fb_ghr=0, no requests -> counter 1->2->3, prediction TAKEN. Two more TAKEN leave it at 3. Four NOT_TAKEN take it to 0 (no wrap).
3. GHR_BITS=4: four requests predicted TAKEN,TAKEN,NOT_TAKEN,TAKEN from ghr=0 -> o_req_ghr = 0,1,3,6 and ghr=0xD.
4. ghr=0xD, feedback i_fb_ghr=0x1, prediction TAKEN, outcome NOT_TAKEN, with a request in the same cycle -> ghr=0x2 next cycle; o_stat_mispredicts +1, o_stat_branches +1.
5. Aliasing check: PC 0x44 with ghr=0 and PC 0x40 with ghr=1 map to the same index. Train via one, request via the other -> same counter observed. A same-cycle request and feedback on that entry returns the old value, then the new one the next cycle.
6. Reset mid-RUN after training entries to 3 -> INIT re-sweeps; after o_ready, all requests predict NOT_TAKEN, ghr=0, stats=0.
